// File: rtl/dwhh_grad_update_pkg.sv
// ---------------------------------------------------------------------------
// dwhh_grad_update_pkg
//   Shared widths, types, FSM encoding and saturation helpers for the W_hh
//   gradient-accumulate / SGD-update block.
//   Fixed-point words carry FRAC_BITS fractional bits (ONE_FX = 1.0).
// ---------------------------------------------------------------------------
package dwhh_grad_update_pkg;

    localparam int DATABIT   = 16;
    localparam int FRAC_BITS = 12;
    localparam int ACCBIT    = 24;
    localparam int WNUM      = 64;
    localparam int TBIT      = 8;
    localparam int LANES     = 4;
    localparam int PRODBIT   = ACCBIT + DATABIT;
    localparam int ONE_FX    = 1 << FRAC_BITS;

    typedef logic signed [DATABIT-1:0] data_t;
    typedef logic signed [DATABIT:0]   diff_t;
    typedef logic signed [ACCBIT-1:0]  acc_t;
    typedef logic signed [ACCBIT:0]    accsum_t;
    typedef logic signed [PRODBIT-1:0] prod_t;
    typedef logic [1:0]                lane_t;

    localparam lane_t LANE_LAST = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_SCALE,
        ST_UPDATE,
        ST_DONE
    } state_e;

    // Saturation bounds expressed at the widest working width.
    localparam prod_t DATA_MAX_P = prod_t'((64'sd1 <<< (DATABIT - 1)) - 64'sd1);
    localparam prod_t DATA_MIN_P = -DATA_MAX_P - prod_t'(1);
    localparam accsum_t ACC_MAX_S = accsum_t'((64'sd1 <<< (ACCBIT - 1)) - 64'sd1);
    localparam accsum_t ACC_MIN_S = -ACC_MAX_S - accsum_t'(1);

    // Clamp any signed value (sign-extended to PRODBIT) into a data word.
    function automatic data_t sat_to_data(input prod_t x);
        if (x > DATA_MAX_P) begin
            return data_t'(DATA_MAX_P);
        end else if (x < DATA_MIN_P) begin
            return data_t'(DATA_MIN_P);
        end
        return data_t'(x);
    endfunction

    // Clamp a one-bit-wider accumulator sum back into the accumulator range.
    function automatic acc_t sat_to_acc(input accsum_t x);
        if (x > ACC_MAX_S) begin
            return acc_t'(ACC_MAX_S);
        end else if (x < ACC_MIN_S) begin
            return acc_t'(ACC_MIN_S);
        end
        return acc_t'(x);
    endfunction

endpackage

// File: rtl/dwhh_grad_update_if.sv
// ---------------------------------------------------------------------------
// dwhh_grad_update_if
//   Bundles the control, gradient and weight-slice signals of
//   dwhh_grad_update.
//   master : the side that issues start / gradients (sequencer, bench)
//   slave  : the update block itself
//   Signals
//     start, seq_len, lr, w_in        run setup (sampled on start)
//     grad_valid, grad_0..grad_3      upstream gradient stage results
//     busy, w_valid, w_out, step_cnt  status and updated weight slice
// ---------------------------------------------------------------------------
interface dwhh_grad_update_if;
    import dwhh_grad_update_pkg::*;

    logic              start;
    logic [TBIT-1:0]   seq_len;
    data_t             lr;
    logic [WNUM-1:0]   w_in;
    logic              grad_valid;
    data_t             grad_0;
    data_t             grad_1;
    data_t             grad_2;
    data_t             grad_3;
    logic              busy;
    logic              w_valid;
    logic [WNUM-1:0]   w_out;
    logic [TBIT-1:0]   step_cnt;

    modport master (
        output start, seq_len, lr, w_in,
        output grad_valid, grad_0, grad_1, grad_2, grad_3,
        input  busy, w_valid, w_out, step_cnt
    );

    modport slave (
        input  start, seq_len, lr, w_in,
        input  grad_valid, grad_0, grad_1, grad_2, grad_3,
        output busy, w_valid, w_out, step_cnt
    );

endinterface

// File: rtl/dwhh_grad_update_sgd_lane_step.sv
// ---------------------------------------------------------------------------
// sgd_lane_step
//   Purely combinational SGD step for one lane:
//     step = sat_DATABIT( (acc * lr) >>> FRAC_BITS )
//   One instance is shared by all four lanes during the SCALE phase.
//   Ports
//     acc  in  ACCBIT  accumulated gradient (signed)
//     lr   in  DATABIT learning rate (signed, FRAC_BITS fraction)
//     step out DATABIT scaled, saturated update step
// ---------------------------------------------------------------------------
module sgd_lane_step
    import dwhh_grad_update_pkg::*;
(
    input  acc_t  acc,
    input  data_t lr,
    output data_t step
);

    prod_t prod;
    prod_t prod_shifted;

    // The full signed product of ACCBIT x DATABIT fits in PRODBIT, so no
    // bits are lost before the fractional realignment.
    assign prod         = prod_t'(acc) * prod_t'(lr);
    assign prod_shifted = prod >>> FRAC_BITS;
    assign step         = sat_to_data(prod_shifted);

endmodule

// File: rtl/dwhh_grad_update.sv
// ---------------------------------------------------------------------------
// dwhh_grad_update
//   Accumulates four-lane dh/dW_hh partial gradients over seq_len BPTT steps
//   in saturating ACCBIT accumulators, then applies one fixed-point SGD step
//   w_new = w - lr * sum(grad) to a packed 4-weight W_hh slice.
//   Ports
//     clk_18  block clock
//     rst_n   asynchronous active-low reset
//     bus     dwhh_grad_update_if.slave
//       start        one-cycle pulse; latches seq_len/lr/w_in in IDLE
//       seq_len      gradients per run (0 behaves as 1)
//       lr           learning rate
//       w_in         current weights, lane i = bits [16i+15:16i]
//       grad_valid   upstream valid; only its rising edge is counted
//       grad_0..3    per-lane gradient
//       busy         high from accepted start through the w_valid cycle
//       w_valid      one-cycle pulse with updated w_out
//       w_out        updated weights, held until the next update or reset
//       step_cnt     gradients accumulated in the current run
// ---------------------------------------------------------------------------
module dwhh_grad_update
    import dwhh_grad_update_pkg::*;
(
    input  logic               clk_18,
    input  logic               rst_n,
    dwhh_grad_update_if.slave  bus
);

    state_e          state_q;
    state_e          state_d;

    logic [TBIT-1:0] seq_len_q;
    logic [TBIT-1:0] step_cnt_q;
    data_t           lr_q;
    data_t           w_q      [LANES];
    acc_t            acc_q    [LANES];
    data_t           step_q   [LANES];
    lane_t           lane_q;
    logic            grad_valid_q;
    logic [WNUM-1:0] w_out_q;

    data_t           grad     [LANES];
    data_t           w_upd    [LANES];
    acc_t            lane_acc;
    data_t           lane_step;

    logic            grad_edge;
    logic            take_grad;
    logic            last_grad;
    logic            accept_start;
    logic            busy_c;
    logic            w_valid_c;

    assign grad[0] = bus.grad_0;
    assign grad[1] = bus.grad_1;
    assign grad[2] = bus.grad_2;
    assign grad[3] = bus.grad_3;

    // A result is counted once per rising edge of grad_valid, no matter how
    // long upstream holds the level.
    assign grad_edge    = bus.grad_valid & ~grad_valid_q;
    assign accept_start = (state_q == ST_IDLE) && bus.start;
    assign take_grad    = (state_q == ST_ACCUM) && grad_edge;
    assign last_grad    = take_grad && ((step_cnt_q + TBIT'(1)) == seq_len_q);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_18 or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: clocked state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of block order.
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and status outputs
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: each output of this block is defaulted first so that no
        // branch can leave a value unassigned and infer a latch.
        state_d   = state_q;
        busy_c    = 1'b1;
        w_valid_c = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                busy_c = 1'b0;
                if (bus.start) begin
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (last_grad) begin
                    state_d = ST_SCALE;
                end
            end
            ST_SCALE: begin
                if (lane_q == LANE_LAST) begin
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                w_valid_c = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shared lane multiplier, walked lane 0..3 during SCALE
    // ------------------------------------------------------------------
    assign lane_acc = acc_q[lane_q];

    sgd_lane_step u_lane_step (
        .acc  (lane_acc),
        .lr   (lr_q),
        .step (lane_step)
    );

    // The difference of two DATABIT words always fits in DATABIT+1, so
    // only the final clamp is needed.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_upd[i] = sat_to_data(prod_t'(diff_t'(w_q[i]) - diff_t'(step_q[i])));
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_18 or negedge rst_n) begin
        if (!rst_n) begin
            seq_len_q    <= '0;
            step_cnt_q   <= '0;
            lr_q         <= '0;
            lane_q       <= '0;
            grad_valid_q <= 1'b0;
            w_out_q      <= '0;
            // NOTE: these small arrays are flops, not RAM, so they take the
            // async reset like any other register.
            for (int i = 0; i < LANES; i++) begin
                w_q[i]    <= '0;
                acc_q[i]  <= '0;
                step_q[i] <= '0;
            end
        end else begin
            // Tracked in every state so a level held through start does not
            // look like a fresh edge once ACCUM is entered.
            grad_valid_q <= bus.grad_valid;

            if (accept_start) begin
                seq_len_q  <= (bus.seq_len == '0) ? TBIT'(1) : bus.seq_len;
                lr_q       <= bus.lr;
                step_cnt_q <= '0;
                lane_q     <= '0;
                for (int i = 0; i < LANES; i++) begin
                    w_q[i]   <= data_t'(bus.w_in[DATABIT*i +: DATABIT]);
                    acc_q[i] <= '0;
                end
            end

            if (take_grad) begin
                step_cnt_q <= step_cnt_q + TBIT'(1);
                for (int i = 0; i < LANES; i++) begin
                    acc_q[i] <= sat_to_acc(accsum_t'(acc_q[i]) + accsum_t'(grad[i]));
                end
            end

            if (state_q == ST_SCALE) begin
                step_q[lane_q] <= lane_step;
                lane_q         <= lane_q + lane_t'(1);
            end

            if (state_q == ST_UPDATE) begin
                for (int i = 0; i < LANES; i++) begin
                    w_out_q[DATABIT*i +: DATABIT] <= w_upd[i];
                end
            end
        end
    end

    assign bus.busy     = busy_c;
    assign bus.w_valid  = w_valid_c;
    assign bus.w_out    = w_out_q;
    assign bus.step_cnt = step_cnt_q;

endmodule

// File: tb/tb_dwhh_grad_update.sv
// ---------------------------------------------------------------------------
// tb_dwhh_grad_update
//   Self-checking bench for dwhh_grad_update. Directed cases plus randomized
//   runs are compared against an arithmetic reference model of the SGD
//   update (integer sums, clamps and scaling).
// ---------------------------------------------------------------------------
module tb_dwhh_grad_update;
    import dwhh_grad_update_pkg::*;

    logic clk_18 = 1'b0;
    logic rst_n;

    always #5 clk_18 = ~clk_18;

    dwhh_grad_update_if bus();

    dwhh_grad_update dut (
        .clk_18 (clk_18),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    longint m_acc [4];
    longint m_w   [4];
    longint m_lr;
    int     m_seq;

    function automatic longint clamp(input longint v, input longint lo, input longint hi);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic logic [63:0] pack4(input int a0, input int a1, input int a2, input int a3);
        return {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
    endfunction

    function automatic void model_start(input int seq, input logic [15:0] lr, input logic [63:0] w);
        m_seq = (seq == 0) ? 1 : seq;
        m_lr  = longint'($signed(lr));
        for (int i = 0; i < 4; i++) begin
            m_w[i]   = longint'($signed(w[16*i +: 16]));
            m_acc[i] = 0;
        end
    endfunction

    function automatic void model_grad(input logic [63:0] g);
        for (int i = 0; i < 4; i++) begin
            m_acc[i] = clamp(m_acc[i] + longint'($signed(g[16*i +: 16])), -(64'sd1 <<< 23), (64'sd1 <<< 23) - 1);
        end
    endfunction

    function automatic logic [63:0] model_result();
        logic [63:0] r;
        longint      stp;
        longint      nw;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            // Floor division by 2^FRAC_BITS of the exact product.
            stp = clamp((m_acc[i] * m_lr) >>> FRAC_BITS, -32768, 32767);
            nw  = clamp(m_w[i] - stp, -32768, 32767);
            r[16*i +: 16] = 16'(nw);
        end
        return r;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive_grad(input logic [63:0] g);
        bus.grad_0 = g[15:0];
        bus.grad_1 = g[31:16];
        bus.grad_2 = g[47:32];
        bus.grad_3 = g[63:48];
    endtask

    // Issues a start pulse; optionally raises grad_valid in the same cycle
    // (that edge must not be counted). Returns at a negedge with
    // grad_valid low.
    task automatic start_run(input int seq, input logic [15:0] lr, input logic [63:0] w,
                             input bit with_edge, input logic [63:0] junk);
        @(negedge clk_18);
        bus.start   = 1'b1;
        bus.seq_len = 8'(seq);
        bus.lr      = lr;
        bus.w_in    = w;
        if (with_edge) begin
            drive_grad(junk);
            bus.grad_valid = 1'b1;
        end
        model_start(seq, lr, w);
        @(negedge clk_18);
        bus.start   = 1'b0;
        bus.seq_len = ~8'(seq);
        bus.lr      = ~lr;
        bus.w_in    = ~w;
        check("busy_after_start", bus.busy, 1);
        check("step_cnt_cleared", bus.step_cnt, 0);
        if (with_edge) begin
            bus.grad_valid = 1'b0;
            @(negedge clk_18);
        end
    endtask

    // Feeds the gradient list, then measures latency and checks the result.
    task automatic feed_and_finish(input string tag, input logic [63:0] grads[$],
                                   input int hold, input int gap);
        int          lat;
        bit          seen;
        logic [63:0] exp_w;
        for (int k = 0; k < grads.size(); k++) begin
            drive_grad(grads[k]);
            bus.grad_valid = 1'b1;
            model_grad(grads[k]);
            if (k < grads.size() - 1) begin
                repeat (hold) @(negedge clk_18);
                check({tag, "_step_cnt"}, bus.step_cnt, 64'(k + 1));
                bus.grad_valid = 1'b0;
                repeat (gap) @(negedge clk_18);
            end
        end
        exp_w = model_result();
        // Count sampling points after the edge that takes the final gradient.
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            @(negedge clk_18);
            lat++;
            if (lat >= hold) bus.grad_valid = 1'b0;
            if (bus.w_valid) seen = 1'b1;
        end
        check({tag, "_latency"}, 64'(lat), 6);
        check({tag, "_w_out"}, bus.w_out, exp_w);
        check({tag, "_busy_at_valid"}, bus.busy, 1);
        check({tag, "_step_cnt_final"}, bus.step_cnt, 64'(m_seq));
        @(negedge clk_18);
        check({tag, "_valid_one_cycle"}, bus.w_valid, 0);
        check({tag, "_busy_clear"}, bus.busy, 0);
        check({tag, "_w_out_held"}, bus.w_out, exp_w);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [63:0] q[$];
        logic [63:0] g;
        int          pulses;

        bus.start      = 1'b0;
        bus.seq_len    = '0;
        bus.lr         = '0;
        bus.w_in       = '0;
        bus.grad_valid = 1'b0;
        drive_grad('0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk_18);
        check("rst_busy", bus.busy, 0);
        check("rst_w_valid", bus.w_valid, 0);
        check("rst_w_out", bus.w_out, 0);
        check("rst_step_cnt", bus.step_cnt, 0);
        rst_n = 1'b1;

        // Gradient edge while idle must be ignored.
        @(negedge clk_18);
        drive_grad(pack4(500, 500, 500, 500));
        bus.grad_valid = 1'b1;
        @(negedge clk_18);
        check("idle_edge_step_cnt", bus.step_cnt, 0);
        check("idle_edge_busy", bus.busy, 0);
        bus.grad_valid = 1'b0;

        // Basic: lr 0.25, two edges of 0.5 on weights of 1.0.
        start_run(2, 16'(1024), pack4(4096, 4096, 4096, 4096), 1'b0, '0);
        q = {pack4(2048, 2048, 2048, 2048), pack4(2048, 2048, 2048, 2048)};
        feed_and_finish("basic", q, 1, 1);
        check("basic_const", bus.w_out, pack4(3072, 3072, 3072, 3072));

        // Held valid: each result held 3 cycles.
        start_run(3, 16'(ONE_FX), pack4(1000, 2000, -3000, 20000), 1'b0, '0);
        g = pack4(100, -100, 0, 4096);
        q = {g, g, g};
        feed_and_finish("held", q, 3, 1);
        check("held_const", bus.w_out, pack4(700, 2300, -3000, 7712));

        // Saturation in both directions.
        start_run(4, 16'(ONE_FX), pack4(32767, -32768, 0, 100), 1'b0, '0);
        g = pack4(-32768, 32767, 0, 1);
        q = {g, g, g, g};
        feed_and_finish("sat", q, 1, 2);
        check("sat_const", bus.w_out, pack4(32767, -32768, 0, 96));

        // seq_len 0 behaves as 1; a start pulse in ACCUM is ignored.
        start_run(0, 16'(ONE_FX), pack4(10, -20, 30, -40), 1'b0, '0);
        bus.start   = 1'b1;
        bus.seq_len = 8'd5;
        bus.lr      = '0;
        bus.w_in    = '0;
        @(negedge clk_18);
        bus.start = 1'b0;
        check("accum_start_busy", bus.busy, 1);
        check("accum_start_step_cnt", bus.step_cnt, 0);
        q = {pack4(1, 1, 1, 1)};
        feed_and_finish("seq0", q, 1, 1);
        check("seq0_const", bus.w_out, pack4(9, -21, 29, -41));

        // start and a gradient edge in the same cycle: the edge is dropped.
        start_run(1, 16'(ONE_FX), pack4(100, 200, 300, 400), 1'b1, pack4(7777, 7777, 7777, 7777));
        q = {pack4(5, 6, 7, 8)};
        feed_and_finish("start_edge", q, 1, 1);
        check("start_edge_const", bus.w_out, pack4(95, 194, 293, 392));

        // Reset during SCALE discards the run.
        start_run(1, 16'(ONE_FX), pack4(1, 2, 3, 4), 1'b0, '0);
        drive_grad(pack4(9, 9, 9, 9));
        bus.grad_valid = 1'b1;
        repeat (2) @(negedge clk_18);
        rst_n = 1'b0;
        #1;
        check("midrst_w_out", bus.w_out, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_step_cnt", bus.step_cnt, 0);
        bus.grad_valid = 1'b0;
        @(negedge clk_18);
        rst_n  = 1'b1;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_18);
            if (bus.w_valid) pulses++;
        end
        check("midrst_no_valid", 64'(pulses), 0);
        start_run(2, 16'(2048), pack4(-100, 100, 5000, -5000), 1'b0, '0);
        q = {pack4(40, -40, 400, 4000), pack4(20, 60, -4, 100)};
        feed_and_finish("post_rst", q, 2, 1);

        // Randomized runs.
        for (int r = 0; r < 16; r++) begin
            int          seq;
            logic [15:0] lr;
            logic [63:0] w;
            seq = int'($urandom_range(1, 5));
            lr  = (r % 2 == 0) ? 16'($urandom) : 16'($urandom_range(0, 8191));
            w   = {$urandom, $urandom};
            start_run(seq, lr, w, 1'b0, '0);
            q = {};
            for (int k = 0; k < seq; k++) begin
                g = {$urandom, $urandom};
                if (r % 3 == 0) g = g & 64'h00FF_00FF_00FF_00FF;
                q.push_back(g);
            end
            feed_and_finish($sformatf("rnd%0d", r), q,
                            int'($urandom_range(1, 3)), int'($urandom_range(1, 2)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
